// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter and its
// outstanding-read FIFO.
package dmem_port_arbiter_pkg;

    localparam int unsigned DMEM_ARB_MAX_OUTS = 4;
    // Requester id width, wide enough for the largest supported NREQ (4).
    localparam int unsigned ARB_ID_W = 2;

    typedef struct packed {
        logic [ARB_ID_W-1:0] id;
        logic                drop;
    } arb_outs_entry_t;

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strobe;
    } dmem_req_flat_t;

endpackage

// File: rtl/dmem_port_arbiter_outs_fifo.sv
// In-order FIFO of outstanding reads: owner id plus a drop flag that a
// flush sets on every entry so stale responses are swallowed.
module dmem_port_arbiter_outs_fifo
    import dmem_port_arbiter_pkg::*;
#(
    parameter int unsigned Depth = DMEM_ARB_MAX_OUTS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic [ARB_ID_W-1:0]   push_id,
    input  logic                  pop,
    output arb_outs_entry_t       head,
    output logic                  empty,
    output logic [$clog2(Depth):0] count
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [ARB_ID_W-1:0] id_q [Depth];
    logic [Depth-1:0]    drop_q, drop_d;
    logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]     count_q, count_d;

    always_comb begin
        drop_d  = drop_q;
        count_d = count_q;
        if (push) begin
            drop_d[wr_ptr_q] = 1'b0;
        end
        if (flush) begin
            drop_d = '1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    // Id storage is only read behind a non-empty count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            id_q[wr_ptr_q] <= push_id;
        end
    end

    assign head  = '{id: id_q[rd_ptr_q], drop: drop_q[rd_ptr_q]};
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between NREQ load/store requesters and routes
// in-order read responses back. Define DMEM_ARB_RR_EN for round-robin, else fixed priority.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int unsigned NREQ     = 2,
    parameter int unsigned MAX_OUTS = DMEM_ARB_MAX_OUTS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_wen,
    input  logic [NREQ-1:0][31:0] req_addr,
    input  logic [NREQ-1:0][31:0] req_data,
    input  logic [NREQ-1:0][3:0]  req_strobe,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       resp_valid,
    output logic [31:0]           resp_data,
    input  logic [NREQ-1:0]       resp_ready,
    output logic                  mem_req_valid,
    output logic                  mem_req_wen,
    output logic [31:0]           mem_req_addr,
    output logic [31:0]           mem_req_data,
    output logic [3:0]            mem_req_strobe,
    input  logic                  mem_req_ready,
    input  logic                  mem_resp_valid,
    input  logic [31:0]           mem_resp_data,
    output logic                  mem_resp_ready
);

    localparam int unsigned CntW = $clog2(MAX_OUTS) + 1;

    logic                lock_q, lock_d;
    logic [ARB_ID_W-1:0] grant_q, grant_d;
    logic [ARB_ID_W-1:0] start;
    logic [NREQ-1:0]     eligible;
    logic [NREQ-1:0]     sel;
    logic                win_found;
    logic [ARB_ID_W-1:0] win_idx;
    dmem_req_flat_t      win_req;
    logic                accept;
    logic                push;
    logic                pop;
    logic                fifo_empty;
    logic                fifo_room;
    logic [CntW-1:0]     fifo_count;
    arb_outs_entry_t     head;

`ifdef DMEM_ARB_RR_EN
    logic [ARB_ID_W-1:0] rr_ptr_q, rr_ptr_d;
    assign start = rr_ptr_q;
`else
    assign start = '0;
`endif

    // Registered count only: a pop this cycle does not open a slot for a push.
    assign fifo_room = (fifo_count < CntW'(MAX_OUTS));

    always_comb begin
        eligible = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (lock_q) begin
                eligible[i] = req_valid[i] && (grant_q == ARB_ID_W'(i));
            end else begin
                eligible[i] = req_valid[i] && (req_wen[i] || fifo_room);
            end
        end
    end

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (!win_found && eligible[i] && ((int'(start) + k) % int'(NREQ) == i)) begin
                    win_found = 1'b1;
                    win_idx   = ARB_ID_W'(i);
                end
            end
        end
    end

    assign mem_req_valid = win_found && !flush;

    always_comb begin
        sel     = '0;
        win_req = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (mem_req_valid && (win_idx == ARB_ID_W'(i))) begin
                sel[i]  = 1'b1;
                win_req = '{wen: req_wen[i], addr: req_addr[i], data: req_data[i],
                            strobe: req_strobe[i]};
            end
        end
    end

    assign mem_req_wen    = win_req.wen;
    assign mem_req_addr   = win_req.addr;
    assign mem_req_data   = win_req.data;
    assign mem_req_strobe = win_req.strobe;
    assign req_ready      = sel & {NREQ{mem_req_ready}};
    assign accept         = mem_req_valid && mem_req_ready;
    assign push           = accept && !win_req.wen;

    always_comb begin
        lock_d  = lock_q;
        grant_d = grant_q;
        if (flush) begin
            lock_d = 1'b0;
        end else if (mem_req_valid && !mem_req_ready) begin
            lock_d  = 1'b1;
            grant_d = win_idx;
        end else if (accept) begin
            lock_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q  <= 1'b0;
            grant_q <= '0;
        end else begin
            lock_q  <= lock_d;
            grant_q <= grant_d;
        end
    end

`ifdef DMEM_ARB_RR_EN
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (win_idx == ARB_ID_W'(NREQ - 1)) ? '0 : win_idx + ARB_ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // Orphan and flushed responses are always taken so the memory never stalls.
    always_comb begin
        resp_valid     = '0;
        mem_resp_ready = 1'b0;
        if (fifo_empty) begin
            mem_resp_ready = mem_resp_valid;
        end else if (head.drop) begin
            mem_resp_ready = 1'b1;
        end else begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (head.id == ARB_ID_W'(i)) begin
                    resp_valid[i]  = mem_resp_valid;
                    mem_resp_ready = resp_ready[i];
                end
            end
        end
    end

    assign resp_data = (|resp_valid) ? mem_resp_data : '0;
    assign pop       = mem_resp_valid && mem_resp_ready && !fifo_empty;

    dmem_port_arbiter_outs_fifo #(
        .Depth (MAX_OUTS)
    ) u_outs_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .push    (push),
        .push_id (win_idx),
        .pop     (pop),
        .head    (head),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && mem_resp_valid && fifo_empty) begin
            $warning("dmem_port_arbiter: read response with no outstanding read, discarded");
        end
    end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: a queue-based model checked every cycle plus
// directed scenarios with literal expectations.
module tb_dmem_port_arbiter;

    localparam int NREQ     = 2;
    localparam int MAX_OUTS = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  flush;
    logic [NREQ-1:0]       req_valid, req_wen, req_ready, resp_valid, resp_ready;
    logic [NREQ-1:0][31:0] req_addr, req_data;
    logic [NREQ-1:0][3:0]  req_strobe;
    logic [31:0]           resp_data, mem_req_addr, mem_req_data, mem_resp_data;
    logic [3:0]            mem_req_strobe;
    logic                  mem_req_valid, mem_req_wen, mem_req_ready;
    logic                  mem_resp_valid, mem_resp_ready;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(
        .NREQ     (NREQ),
        .MAX_OUTS (MAX_OUTS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .req_valid      (req_valid),
        .req_wen        (req_wen),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .req_strobe     (req_strobe),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .resp_ready     (resp_ready),
        .mem_req_valid  (mem_req_valid),
        .mem_req_wen    (mem_req_wen),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_req_strobe (mem_req_strobe),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .mem_resp_ready (mem_resp_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: owners of outstanding reads kept as a queue; lock and pointer as plain ints.
    int          q_id[$];
    bit          q_drop[$];
    bit          m_lock;
    int          m_gid;
    int          m_rr;
    int          m_win;
    bit          m_mv;
    logic [1:0]  m_exp_rr;
    logic [1:0]  m_exp_rv;
    logic        m_exp_mrr;

    always @(negedge clk) begin
        if (rst) begin
            q_id.delete();
            q_drop.delete();
            m_lock = 1'b0;
            m_gid  = 0;
            m_rr   = 0;
        end else begin
            m_win = -1;
            if (m_lock) begin
                if (req_valid[m_gid]) m_win = m_gid;
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    if (m_win < 0 && req_valid[(m_rr + k) % NREQ] &&
                        (req_wen[(m_rr + k) % NREQ] || q_id.size() < MAX_OUTS))
                        m_win = (m_rr + k) % NREQ;
                end
            end
            m_mv = (m_win >= 0) && !flush;
            check("mem_req_valid", mem_req_valid, m_mv);
            if (m_mv) begin
                check("mem_req_wen", mem_req_wen, req_wen[m_win]);
                check("mem_req_addr", mem_req_addr, req_addr[m_win]);
                check("mem_req_data", mem_req_data, req_data[m_win]);
                check("mem_req_strobe", mem_req_strobe, req_strobe[m_win]);
            end
            m_exp_rr = '0;
            if (m_mv && mem_req_ready) m_exp_rr[m_win] = 1'b1;
            check("req_ready", req_ready, m_exp_rr);

            m_exp_rv  = '0;
            m_exp_mrr = mem_resp_valid;
            if (q_id.size() > 0) begin
                if (q_drop[0]) begin
                    m_exp_mrr = 1'b1;
                end else begin
                    m_exp_mrr = resp_ready[q_id[0]];
                    if (mem_resp_valid) m_exp_rv[q_id[0]] = 1'b1;
                end
            end
            check("resp_valid", resp_valid, m_exp_rv);
            if (mem_resp_valid || q_id.size() > 0) check("mem_resp_ready", mem_resp_ready, m_exp_mrr);
            if (m_exp_rv != 0) check("resp_data", resp_data, mem_resp_data);

            if (mem_resp_valid && m_exp_mrr && q_id.size() > 0) begin
                void'(q_id.pop_front());
                void'(q_drop.pop_front());
            end
            if (m_mv && mem_req_ready && !req_wen[m_win]) begin
                q_id.push_back(m_win);
                q_drop.push_back(1'b0);
            end
            if (flush) begin
                foreach (q_drop[j]) q_drop[j] = 1'b1;
            end
            if (flush) m_lock = 1'b0;
            else if (m_mv && !mem_req_ready) begin
                m_lock = 1'b1;
                m_gid  = m_win;
            end else if (m_mv && mem_req_ready) m_lock = 1'b0;
`ifdef DMEM_ARB_RR_EN
            if (m_mv && mem_req_ready) m_rr = (m_win + 1) % NREQ;
`endif
        end
    end

    task automatic idle_inputs();
        flush          = 1'b0;
        req_valid      = '0;
        req_wen        = '0;
        req_addr       = '0;
        req_data       = '0;
        req_strobe     = '0;
        resp_ready     = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        sample();
    endtask

    logic [31:0] t1_addr [3];
    logic [1:0]  t1_rdy  [3];

    initial begin
        rst = 1'b1;
        idle_inputs();
`ifdef DMEM_ARB_RR_EN
        t1_addr = '{32'h100, 32'h200, 32'h100};
        t1_rdy  = '{2'b01, 2'b10, 2'b01};
`else
        t1_addr = '{32'h100, 32'h100, 32'h100};
        t1_rdy  = '{2'b01, 2'b01, 2'b01};
`endif

        // Reset state, then two competing loads.
        do_reset();
        check("rst_mem_req_valid", mem_req_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_mem_resp_ready", mem_resp_ready, 0);
        step();
        req_valid = 2'b11;
        req_addr[0] = 32'h100;
        req_addr[1] = 32'h200;
        mem_req_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) step();
            sample();
            check("t1_grant_addr", mem_req_addr, t1_addr[c]);
            check("t1_req_ready", req_ready, t1_rdy[c]);
        end

        // Stalled store holds the grant; the load follows after acceptance.
        do_reset();
        step();
        req_valid = 2'b10; req_wen = 2'b10;
        req_addr[1] = 32'h40; req_data[1] = 32'hA5A5_0001; req_strobe[1] = 4'h1;
        sample();
        check("t2_addr_c0", mem_req_addr, 32'h40);
        check("t2_rdy_c0", req_ready, 2'b00);
        step();
        req_valid = 2'b11; req_addr[0] = 32'h100;
        sample();
        check("t2_addr_c1", mem_req_addr, 32'h40);
        step();
        sample();
        check("t2_addr_c2", mem_req_addr, 32'h40);
        check("t2_rdy_c2", req_ready, 2'b00);
        step();
        mem_req_ready = 1'b1;
        sample();
        check("t2_addr_c3", mem_req_addr, 32'h40);
        check("t2_rdy_c3", req_ready, 2'b10);
        step();
        req_valid = 2'b01; req_wen = 2'b00;
        sample();
        check("t2_load_addr", mem_req_addr, 32'h100);
        check("t2_load_rdy", req_ready, 2'b01);

        // Full FIFO blocks loads but not stores.
        do_reset();
        step();
        req_valid = 2'b01; req_addr[0] = 32'h100; mem_req_ready = 1'b1;
        sample();
        for (int c = 0; c < 3; c++) begin
            step();
            sample();
        end
        step();
        req_valid = 2'b11; req_wen = 2'b10; req_addr[1] = 32'h80;
        sample();
        check("t3_store_rdy", req_ready, 2'b10);
        check("t3_store_addr", mem_req_addr, 32'h80);
        step();
        req_valid = 2'b01; req_wen = 2'b00;
        mem_resp_valid = 1'b1; mem_resp_data = 32'h11; resp_ready = 2'b11;
        sample();
        check("t3_blocked", mem_req_valid, 0);
        check("t3_resp_valid", resp_valid, 2'b01);
        step();
        mem_resp_valid = 1'b0;
        sample();
        check("t3_fifth_rdy", req_ready, 2'b01);

        // In-order response routing with an owner stall.
        do_reset();
        step();
        req_valid = 2'b01; req_addr[0] = 32'h100; mem_req_ready = 1'b1;
        sample();
        step();
        req_valid = 2'b10; req_addr[1] = 32'h200;
        sample();
        check("t4_second_rdy", req_ready, 2'b10);
        step();
        req_valid = 2'b00;
        mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_BEEF; resp_ready = 2'b10;
        sample();
        check("t4_stall_c0", mem_resp_ready, 0);
        step();
        sample();
        check("t4_stall_c1", mem_resp_ready, 0);
        step();
        resp_ready = 2'b11;
        sample();
        check("t4_rv0", resp_valid, 2'b01);
        check("t4_rd0", resp_data, 32'hDEAD_BEEF);
        step();
        mem_resp_data = 32'h1234_5678;
        sample();
        check("t4_rv1", resp_valid, 2'b10);
        check("t4_rd1", resp_data, 32'h1234_5678);

        // Flush drops in-flight reads; a later load routes normally.
        do_reset();
        step();
        req_valid = 2'b01; req_addr[0] = 32'h100; mem_req_ready = 1'b1;
        sample();
        step();
        req_valid = 2'b10; req_addr[1] = 32'h200;
        sample();
        step();
        req_valid = 2'b01; flush = 1'b1;
        sample();
        check("t5_flush_mv", mem_req_valid, 0);
        check("t5_flush_rdy", req_ready, 0);
        for (int c = 0; c < 2; c++) begin
            step();
            flush = 1'b0; req_valid = 2'b00;
            mem_resp_valid = 1'b1; mem_resp_data = 32'hBAD0_0001 + c; resp_ready = 2'b00;
            sample();
            check("t5_drop_ready", mem_resp_ready, 1);
            check("t5_drop_rv", resp_valid, 0);
        end
        step();
        mem_resp_valid = 1'b0; req_valid = 2'b10; req_addr[1] = 32'h300;
        sample();
        check("t5_new_rdy", req_ready, 2'b10);
        step();
        req_valid = 2'b00;
        mem_resp_valid = 1'b1; mem_resp_data = 32'hCAFE_0001; resp_ready = 2'b11;
        sample();
        check("t5_new_rv", resp_valid, 2'b10);
        check("t5_new_rd", resp_data, 32'hCAFE_0001);

        // Orphan response with nothing outstanding.
        do_reset();
        step();
        mem_resp_valid = 1'b1; mem_resp_data = 32'h5555_5555;
        sample();
        check("t6_orphan_ready", mem_resp_ready, 1);
        check("t6_orphan_rv", resp_valid, 0);
        step();
        idle_inputs();
        step();
        sample();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
